aes_sram_responder: RTL and testbench

Memory-side responder for the 128-bit word SRAM interface that the AES round blocks drive with read/write/addr/value strobes. It holds the AES state and round-key words, serves one read or one write per cycle with fixed one-cycle response latency, and provides a multi-cycle clear sweep. It replaces the behavioural test SRAM in synthesizable builds.

---
 rtl/aes_sram_responder.sv | 121 ++++++++++++
 tb/tb_aes_sram_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/aes_sram_responder.sv
// 128-bit word SRAM responder for the AES round blocks: one read or write per
// cycle with one-cycle registered response, plus a word-per-cycle clear sweep.
module aes_sram_responder #(
  parameter int NUM_WORDS = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         read,
  input  logic         write,
  input  logic [15:0]  addr,
  input  logic [127:0] value_in,
  input  logic         clear,
  output logic [127:0] value_out,
  output logic         read_valid,
  output logic         write_done,
  output logic         busy,
  output logic         error
);

  localparam int AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] CLEARING = 1'b1;

  logic [0:0]                  state_q, state_d;
  logic [11:0]                 cnt_q, cnt_d;
  logic [NUM_WORDS-1:0][127:0] mem_q;
  logic [127:0]                value_out_q, value_out_d;
  logic                        read_valid_q, read_valid_d;
  logic                        write_done_q, write_done_d;
  logic                        error_q, error_d;

  logic          wr_en;
  logic [AW-1:0] wr_idx;
  logic [127:0]  wr_data;
  logic [AW-1:0] req_idx;
  logic          req_bad;

  assign req_idx = addr[4 +: AW];
  // Out-of-range compare is widened so NUM_WORDS=4096 does not wrap to zero.
  assign req_bad = (addr[3:0] != 4'h0)
                 | ({1'b0, addr[15:4]} >= 13'(NUM_WORDS))
                 | (read & write);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    value_out_d  = value_out_q;
    read_valid_d = 1'b0;
    write_done_d = 1'b0;
    error_d      = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = req_idx;
    wr_data      = value_in;
    case (state_q)
      IDLE: begin
        if (clear) begin
          // Clear has priority; any request on the same edge is rejected.
          state_d = CLEARING;
          cnt_d   = 12'd0;
          error_d = read | write;
        end else if (read | write) begin
          if (req_bad) begin
            error_d = 1'b1;
          end else if (write) begin
            wr_en        = 1'b1;
            write_done_d = 1'b1;
          end else begin
            value_out_d  = mem_q[req_idx];
            read_valid_d = 1'b1;
          end
        end
      end
      CLEARING: begin
        error_d = read | write;
        wr_en   = 1'b1;
        wr_idx  = cnt_q[AW-1:0];
        wr_data = '0;
        cnt_d   = cnt_q + 12'd1;
        if (cnt_q == 12'(NUM_WORDS - 1)) begin
          state_d = IDLE;
          cnt_d   = 12'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= 12'd0;
      value_out_q  <= '0;
      read_valid_q <= 1'b0;
      write_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      value_out_q  <= value_out_d;
      read_valid_q <= read_valid_d;
      write_done_q <= write_done_d;
      error_q      <= error_d;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign value_out  = value_out_q;
  assign read_valid = read_valid_q;
  assign write_done = write_done_q;
  assign error      = error_q;
  assign busy       = (state_q == CLEARING);

endmodule

// File: tb/tb_aes_sram_responder.sv
// Randomized and directed bench for aes_sram_responder against a
// transaction-level memory model that tracks the clear sweep as a word count.
module tb_aes_sram_responder;

  localparam int N = 16;
  localparam logic [127:0] DATA0 = 128'h00112233445566778899AABBCCDDEEFF;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         read = 1'b0, write = 1'b0, clear = 1'b0;
  logic [15:0]  addr = '0;
  logic [127:0] value_in = '0;
  logic [127:0] value_out;
  logic         read_valid, write_done, busy, error;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [127:0] m_mem [N];
  logic [127:0] m_vo;
  logic         m_rv, m_wd, m_err;
  int           m_left;
  int           m_sweep;

  aes_sram_responder #(.NUM_WORDS(N)) dut (
    .clk(clk), .n_rst(n_rst), .read(read), .write(write), .addr(addr),
    .value_in(value_in), .clear(clear), .value_out(value_out),
    .read_valid(read_valid), .write_done(write_done), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_mem[i] = '0;
    m_vo = '0; m_rv = 0; m_wd = 0; m_err = 0; m_left = 0; m_sweep = 0;
  endtask

  task automatic model_edge(input logic r, input logic w, input logic [15:0] a,
                            input logic [127:0] d, input logic c);
    m_rv = 0; m_wd = 0; m_err = 0;
    if (m_left > 0) begin
      if (r || w) m_err = 1;
      m_mem[m_sweep] = '0;
      m_sweep++;
      m_left--;
    end else if (c) begin
      if (r || w) m_err = 1;
      m_left = N;
      m_sweep = 0;
    end else if (r || w) begin
      if (a[3:0] != 0 || int'(a[15:4]) >= N || (r && w)) m_err = 1;
      else if (w) begin m_mem[a[15:4]] = d; m_wd = 1; end
      else begin m_vo = m_mem[a[15:4]]; m_rv = 1; end
    end
  endtask

  task automatic check_outs();
    chk("value_out", value_out, m_vo);
    chk("read_valid", 128'(read_valid), 128'(m_rv));
    chk("write_done", 128'(write_done), 128'(m_wd));
    chk("error", 128'(error), 128'(m_err));
    chk("busy", 128'(busy), 128'(m_left > 0));
  endtask

  // one clock edge with the given request, then compare every output
  task automatic step(input logic r, input logic w, input logic [15:0] a,
                      input logic [127:0] d, input logic c);
    read = r; write = w; addr = a; value_in = d; clear = c;
    @(posedge clk);
    model_edge(r, w, a, d, c);
    #1;
    check_outs();
  endtask

  task automatic idle();
    step(0, 0, 16'h0, '0, 0);
  endtask

  initial begin
    int nb;
    model_reset();
    #12;
    chk("rst_value_out", value_out, '0);
    chk("rst_busy", 128'(busy), 128'(0));
    @(negedge clk) n_rst = 1'b1;
    idle();

    // write then read
    step(0, 1, 16'h0010, DATA0, 0);
    chk("wr_done_pulse", 128'(write_done), 128'(1));
    step(1, 0, 16'h0010, '0, 0);
    chk("rd_data", value_out, DATA0);
    chk("rd_valid_pulse", 128'(read_valid), 128'(1));
    idle();

    // back-to-back traffic
    for (int i = 0; i < N; i++) step(0, 1, 16'(i << 4), 128'(i), 0);
    for (int i = 0; i < N; i++) begin
      step(1, 0, 16'(i << 4), '0, 0);
      chk("b2b_data", value_out, 128'(i));
      chk("b2b_valid", 128'(read_valid), 128'(1));
    end

    // rejected requests
    step(0, 1, 16'h0010, DATA0, 0);
    step(1, 0, 16'h0014, '0, 0);
    chk("misaligned_err", 128'(error), 128'(1));
    step(0, 1, 16'h0100, 128'hDEAD, 0);
    chk("range_err", 128'(error), 128'(1));
    step(1, 1, 16'h0010, 128'hBEEF, 0);
    chk("conflict_err", 128'(error), 128'(1));
    chk("conflict_vo_kept", value_out, 128'(15));
    step(1, 0, 16'h0010, '0, 0);
    chk("rejected_mem_kept", value_out, DATA0);

    // clear sweep with read in sweep cycle 5
    step(0, 0, 16'h0, '0, 1);
    nb = busy ? 1 : 0;
    for (int k = 1; k < 40 && busy; k++) begin
      step(k == 5, 0, 16'h0030, '0, 0);
      if (k == 5) chk("sweep_read_err", 128'(error), 128'(1));
      if (busy) nb++;
    end
    chk("busy_cycles", 128'(nb), 128'(N));
    for (int i = 0; i < N; i++) begin
      step(1, 0, 16'(i << 4), '0, 0);
      chk("cleared_word", value_out, '0);
    end

    // clear priority over a same-edge write
    step(0, 1, 16'h0020, DATA0, 0);
    step(0, 1, 16'h0020, 128'h55, 1);
    chk("clr_prio_err", 128'(error), 128'(1));
    for (int k = 0; k < N; k++) idle();
    step(1, 0, 16'h0020, '0, 0);
    chk("clr_prio_word2", value_out, '0);

    // reset during sweep cycle 7
    step(0, 1, 16'h0000, DATA0, 0);
    step(0, 0, 16'h0, '0, 1);
    for (int k = 0; k < 6; k++) idle();
    @(negedge clk) n_rst = 1'b0;
    #1;
    model_reset();
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_err", 128'(error), 128'(0));
    chk("midrst_vo", value_out, '0);
    @(negedge clk) n_rst = 1'b1;
    step(1, 0, 16'h0000, '0, 0);
    chk("post_rst_rv", 128'(read_valid), 128'(1));
    chk("post_rst_vo", value_out, '0);

    // randomized traffic
    for (int k = 0; k < 2000; k++) begin
      logic [1:0]  op;
      logic [15:0] a;
      logic        c;
      op = 2'($urandom_range(0, 9) < 8 ? $urandom_range(0, 2) : 3);
      if ($urandom_range(0, 9) < 8) a = 16'($urandom_range(0, N - 1) << 4);
      else a = 16'($urandom);
      c = ($urandom_range(0, 59) == 0);
      step(op[0], op[1], a, {$urandom, $urandom, $urandom, $urandom}, c);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
